hv_fault_mgr: RTL and testbench

Fault manager for the HV die. It takes the six synchronized analog fault flags (VCC UV, VCC OV, OT, OC, DESAT, SCP) and deglitches each one. It latches qualified faults into sticky status, forces the gate driver off, and sequences fault clearing and recovery through a request/acknowledge handshake. It sits between the analog fault synchronizers and the HV gate-drive/status logic.

---
 rtl/hv_fault_mgr_pkg.sv | 36 +++
 rtl/hv_fault_mgr_if.sv | 23 ++
 rtl/hv_flt_dgl.sv | 42 ++++
 rtl/hv_fault_mgr.sv | 109 ++++++++++
 tb/tb_hv_fault_mgr.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hv_fault_mgr_pkg.sv
// Shared types and constants for the HV fault manager.
package hv_fault_pkg;

    typedef enum logic [1:0] {
        ST_NORM  = 2'd0,
        ST_FAULT = 2'd1,
        ST_REC   = 2'd2
    } fsm_st_t;

    localparam int FLT_UV    = 0;
    localparam int FLT_OV    = 1;
    localparam int FLT_OT    = 2;
    localparam int FLT_OC    = 3;
    localparam int FLT_DESAT = 4;
    localparam int FLT_SCP   = 5;

    localparam logic [2:0] CODE_NONE  = 3'd0;
    localparam logic [2:0] CODE_UV    = 3'd1;
    localparam logic [2:0] CODE_OV    = 3'd2;
    localparam logic [2:0] CODE_OT    = 3'd3;
    localparam logic [2:0] CODE_OC    = 3'd4;
    localparam logic [2:0] CODE_DESAT = 3'd5;
    localparam logic [2:0] CODE_SCP   = 3'd6;

    // Highest-priority fault present in a sticky vector; SCP is the most severe.
    function automatic logic [2:0] flt_code_f(input logic [5:0] s);
        if (s[FLT_SCP])        return CODE_SCP;
        else if (s[FLT_DESAT]) return CODE_DESAT;
        else if (s[FLT_OC])    return CODE_OC;
        else if (s[FLT_OT])    return CODE_OT;
        else if (s[FLT_OV])    return CODE_OV;
        else if (s[FLT_UV])    return CODE_UV;
        else                   return CODE_NONE;
    endfunction

endpackage

// File: rtl/hv_fault_mgr_if.sv
// Fault flag inputs, clear handshake and status outputs of the fault manager.
interface hv_fault_mgr_if #(
    parameter int FLT_NUM = 6
);
    logic [FLT_NUM-1:0] i_flt;
    logic [FLT_NUM-1:0] i_flt_mask;
    logic               i_clr_req;
    logic               o_clr_ack;
    logic [FLT_NUM-1:0] o_flt_sticky;
    logic [2:0]         o_flt_code;
    logic               o_drv_off;
    logic [1:0]         o_fsm_st;

    modport master (
        output i_flt, i_flt_mask, i_clr_req,
        input  o_clr_ack, o_flt_sticky, o_flt_code, o_drv_off, o_fsm_st
    );

    modport slave (
        input  i_flt, i_flt_mask, i_clr_req,
        output o_clr_ack, o_flt_sticky, o_flt_code, o_drv_off, o_fsm_st
    );
endinterface

// File: rtl/hv_flt_dgl.sv
// Single-bit fault deglitcher. Slow bits need DGL_CYC consecutive unmasked
// high samples; fast bits qualify immediately.
module hv_flt_dgl #(
    parameter int DGL_CYC = 8,
    parameter bit FAST    = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_flt,
    input  logic i_mask,
    output logic o_qual
);

    logic w_act;
    assign w_act = i_flt & ~i_mask;

    if (FAST) begin : g_fast
        // Fast path has no state; clock and reset are intentionally unused here.
        logic w_unused;
        assign w_unused = i_clk | i_rst;
        assign o_qual   = w_act;
    end else begin : g_slow
        localparam logic [3:0] CNT_SAT = 4'(DGL_CYC);
        localparam logic [3:0] CNT_HIT = 4'(DGL_CYC - 1);
        logic [3:0] r_cnt;

        // Count consecutive unmasked high samples, saturating so the pulse fires once.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)
                r_cnt <= '0;
            else if (!w_act)
                r_cnt <= '0;
            else if (r_cnt != CNT_SAT)
                r_cnt <= r_cnt + 4'd1;
        end

        // Not gated by the mask: a count already at the threshold still
        // qualifies if the mask rises on the final sample.
        assign o_qual = i_flt & (r_cnt == CNT_HIT);
    end

endmodule

// File: rtl/hv_fault_mgr.sv
// HV fault manager: deglitches fault flags, latches sticky status, forces the
// gate driver off and sequences clear/recovery.
//
// state | meaning
// NORM  | no fault, driver enabled
// FAULT | qualified fault latched, driver off, waiting for an accepted clear
// REC   | recovery hold-off countdown, driver off
module hv_fault_mgr
    import hv_fault_pkg::*;
#(
    parameter int                 FLT_NUM  = 6,
    parameter int                 DGL_CYC  = 8,
    parameter logic [FLT_NUM-1:0] FAST_MSK = 6'b110000,
    parameter int                 REC_CYC  = 16
) (
    input logic            i_clk,
    input logic            i_rst,
    hv_fault_mgr_if.slave  bus
);

    localparam logic [7:0] REC_LOAD = 8'(REC_CYC);

    logic [FLT_NUM-1:0] w_qual;
    logic [FLT_NUM-1:0] w_sticky_nxt;
    logic [FLT_NUM-1:0] r_sticky;
    fsm_st_t            r_state;
    fsm_st_t            w_state_nxt;
    logic [7:0]         r_rec_cnt;
    logic [7:0]         w_rec_cnt_nxt;
    logic               w_clr_acc;
    logic               r_clr_ack;
    logic               r_drv_off;
    logic [2:0]         r_flt_code;

    for (genvar gi = 0; gi < FLT_NUM; gi++) begin : g_dgl
        hv_flt_dgl #(
            .DGL_CYC (DGL_CYC),
            .FAST    (FAST_MSK[gi])
        ) u_dgl (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_flt  (bus.i_flt[gi]),
            .i_mask (bus.i_flt_mask[gi]),
            .o_qual (w_qual[gi])
        );
    end

    // Next state, recovery count, clear acceptance and next sticky vector.
    always_comb begin
        w_state_nxt   = r_state;
        w_rec_cnt_nxt = r_rec_cnt;
        w_clr_acc     = 1'b0;
        case (r_state)
            ST_NORM: begin
                if (|w_qual)
                    w_state_nxt = ST_FAULT;
            end
            ST_FAULT: begin
                w_clr_acc = bus.i_clr_req && ((bus.i_flt & ~bus.i_flt_mask) == '0);
                if (w_clr_acc)
                    w_rec_cnt_nxt = REC_LOAD;
                // A qualify pulse coinciding with the clear keeps us in FAULT.
                if (|w_qual)
                    w_state_nxt = ST_FAULT;
                else if (w_clr_acc)
                    w_state_nxt = ST_REC;
            end
            ST_REC: begin
                if (|w_qual)
                    w_state_nxt = ST_FAULT;
                else if (r_rec_cnt == 8'd1)
                    w_state_nxt = ST_NORM;
                else
                    w_rec_cnt_nxt = r_rec_cnt - 8'd1;
            end
            default: begin
                w_state_nxt   = ST_REC;
                w_rec_cnt_nxt = REC_LOAD;
            end
        endcase
        w_sticky_nxt = (w_clr_acc ? '0 : r_sticky) | w_qual;
    end

    // State, counter and all registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_REC;
            r_rec_cnt  <= REC_LOAD;
            r_sticky   <= '0;
            r_flt_code <= CODE_NONE;
            r_clr_ack  <= 1'b0;
            r_drv_off  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_rec_cnt  <= w_rec_cnt_nxt;
            r_sticky   <= w_sticky_nxt;
            r_flt_code <= flt_code_f(w_sticky_nxt);
            r_clr_ack  <= w_clr_acc;
            r_drv_off  <= (w_state_nxt != ST_NORM);
        end
    end

    assign bus.o_clr_ack    = r_clr_ack;
    assign bus.o_flt_sticky = r_sticky;
    assign bus.o_flt_code   = r_flt_code;
    assign bus.o_drv_off    = r_drv_off;
    assign bus.o_fsm_st     = r_state;

endmodule

// File: tb/tb_hv_fault_mgr.sv
// Testbench for hv_fault_mgr: reset sequence, table of hand-derived vectors,
// then randomized stimulus against a behavioural model.
module tb_hv_fault_mgr;

    localparam int         FLT_NUM  = 6;
    localparam int         DGL_CYC  = 8;
    localparam int         REC_CYC  = 16;
    localparam logic [5:0] FAST_MSK = 6'b110000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hv_fault_mgr_if #(.FLT_NUM(FLT_NUM)) bus ();

    hv_fault_mgr #(
        .FLT_NUM  (FLT_NUM),
        .DGL_CYC  (DGL_CYC),
        .FAST_MSK (FAST_MSK),
        .REC_CYC  (REC_CYC)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: run lengths of unmasked-high samples, sticky set,
    // mode (0 normal, 1 fault, 2 recovery) and remaining recovery edges.
    int         m_run [FLT_NUM];
    logic [5:0] m_sticky;
    int         m_mode;
    int         m_timer;
    int         m_ack;

    typedef struct {
        logic [5:0] flt;
        logic [5:0] mask;
        logic       clr;
        logic [5:0] sticky;
        logic [2:0] code;
        logic       drv;
        logic [1:0] st;
        logic       ack;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int code_of(input logic [5:0] s);
        int c = 0;
        for (int i = 0; i < FLT_NUM; i++)
            if (s[i]) c = i + 1;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < FLT_NUM; i++) m_run[i] = 0;
        m_sticky = '0;
        m_mode   = 2;
        m_timer  = REC_CYC;
        m_ack    = 0;
    endtask

    task automatic model_step(input logic [5:0] flt, input logic [5:0] mask, input logic clr);
        logic [5:0] act;
        logic [5:0] q;
        bit         acc;
        act = flt & ~mask;
        for (int i = 0; i < FLT_NUM; i++) begin
            if (FAST_MSK[i]) q[i] = act[i];
            else             q[i] = flt[i] && (m_run[i] == DGL_CYC - 1);
        end
        for (int i = 0; i < FLT_NUM; i++)
            m_run[i] = act[i] ? ((m_run[i] < 1000) ? m_run[i] + 1 : m_run[i]) : 0;
        acc      = (m_mode == 1) && clr && (act == 6'b0);
        m_ack    = acc ? 1 : 0;
        m_sticky = (acc ? 6'b0 : m_sticky) | q;
        if (q != 6'b0) begin
            m_mode = 1;
        end else if (acc) begin
            m_mode  = 2;
            m_timer = REC_CYC;
        end else if (m_mode == 2) begin
            m_timer--;
            if (m_timer == 0) m_mode = 0;
        end
    endtask

    // One clock: advance the model with the inputs sampled on this edge, then compare.
    task automatic tick();
        @(posedge clk);
        model_step(bus.i_flt, bus.i_flt_mask, bus.i_clr_req);
        #1;
        chk("model_sticky", bus.o_flt_sticky, m_sticky);
        chk("model_code",   bus.o_flt_code,   code_of(m_sticky));
        chk("model_drv",    bus.o_drv_off,    (m_mode != 0) ? 1 : 0);
        chk("model_st",     bus.o_fsm_st,     m_mode);
        chk("model_ack",    bus.o_clr_ack,    m_ack);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_drv"},    bus.o_drv_off,    1);
        chk({tag, "_st"},     bus.o_fsm_st,     2);
        chk({tag, "_sticky"}, bus.o_flt_sticky, 0);
        chk({tag, "_code"},   bus.o_flt_code,   0);
        chk({tag, "_ack"},    bus.o_clr_ack,    0);
    endtask

    // Asynchronous reset pulse between edges; outputs must change without a clock.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk_reset_vals(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic add(input logic [5:0] flt, input logic [5:0] mask, input logic clr,
                       input logic [5:0] sticky, input logic [2:0] code, input logic drv,
                       input logic [1:0] st, input logic ack);
        vec_t v;
        v.flt = flt; v.mask = mask; v.clr = clr;
        v.sticky = sticky; v.code = code; v.drv = drv; v.st = st; v.ack = ack;
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input logic [5:0] flt, input logic [5:0] mask,
                         input logic clr, input logic [5:0] sticky, input logic [2:0] code,
                         input logic drv, input logic [1:0] st, input logic ack);
        for (int i = 0; i < n; i++) add(flt, mask, clr, sticky, code, drv, st, ack);
    endtask

    logic [5:0] r_flt_hold;

    initial begin
        bus.i_flt      = '0;
        bus.i_flt_mask = '0;
        bus.i_clr_req  = 1'b0;
        model_reset();

        // A: OT deglitch (7 short, then 8), clear gated by raw OC, then accepted clear.
        add_n(7,  6'b000100, 6'b0, 0, 6'b0, 0, 0, 0, 0);
        add      (6'b000000, 6'b0, 0, 6'b0, 0, 0, 0, 0);
        add_n(7,  6'b000100, 6'b0, 0, 6'b0, 0, 0, 0, 0);
        add      (6'b000100, 6'b0, 0, 6'b000100, 3, 1, 1, 0);
        add_n(2,  6'b001000, 6'b0, 1, 6'b000100, 3, 1, 1, 0);
        add      (6'b000000, 6'b0, 1, 6'b0, 0, 1, 2, 1);
        add      (6'b000000, 6'b0, 1, 6'b0, 0, 1, 2, 0);
        add_n(14, 6'b000000, 6'b0, 0, 6'b0, 0, 1, 2, 0);
        add      (6'b000000, 6'b0, 0, 6'b0, 0, 0, 0, 0);
        add      (6'b000000, 6'b0, 1, 6'b0, 0, 0, 0, 0);
        // B: SCP fast path with UV slow path, then DESAT aborting recovery.
        add_n(7,  6'b100001, 6'b0, 0, 6'b100000, 6, 1, 1, 0);
        add      (6'b100001, 6'b0, 0, 6'b100001, 6, 1, 1, 0);
        add      (6'b000000, 6'b0, 1, 6'b0, 0, 1, 2, 1);
        add_n(4,  6'b000000, 6'b0, 0, 6'b0, 0, 1, 2, 0);
        add      (6'b010000, 6'b0, 0, 6'b010000, 5, 1, 1, 0);
        add      (6'b000000, 6'b0, 1, 6'b0, 0, 1, 2, 1);
        add_n(15, 6'b000000, 6'b0, 0, 6'b0, 0, 1, 2, 0);
        add      (6'b000000, 6'b0, 0, 6'b0, 0, 0, 0, 0);
        // C: masked OV held high never qualifies and does not block a clear.
        add_n(10, 6'b000010, 6'b000010, 0, 6'b0, 0, 0, 0, 0);
        add      (6'b100010, 6'b000010, 0, 6'b100000, 6, 1, 1, 0);
        add      (6'b000010, 6'b000010, 1, 6'b0, 0, 1, 2, 1);
        add_n(15, 6'b000010, 6'b000010, 0, 6'b0, 0, 1, 2, 0);
        add      (6'b000010, 6'b000010, 0, 6'b0, 0, 0, 0, 0);
        add      (6'b000000, 6'b000000, 0, 6'b0, 0, 0, 0, 0);
        // D: OT qualifies on the edge its mask rises with a clear: set wins, ack fires.
        add      (6'b100000, 6'b0, 0, 6'b100000, 6, 1, 1, 0);
        add_n(7,  6'b000100, 6'b0, 0, 6'b100000, 6, 1, 1, 0);
        add      (6'b000100, 6'b000100, 1, 6'b000100, 3, 1, 1, 1);
        add      (6'b000000, 6'b000100, 1, 6'b0, 0, 1, 2, 1);
        add_n(15, 6'b000000, 6'b000100, 0, 6'b0, 0, 1, 2, 0);
        add      (6'b000000, 6'b000000, 0, 6'b0, 0, 0, 0, 0);

        // Reset state, then a reset in the middle of recovery reloads the hold-off.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst_init");
        rst = 1'b0;
        repeat (8) tick();
        do_reset("rst_mid_rec");
        for (int n = 1; n <= REC_CYC; n++) begin
            tick();
            if (n < REC_CYC) begin
                chk("rec_hold_drv", bus.o_drv_off, 1);
                chk("rec_hold_st",  bus.o_fsm_st,  2);
            end else begin
                chk("rec_done_drv", bus.o_drv_off, 0);
                chk("rec_done_st",  bus.o_fsm_st,  0);
            end
        end

        for (int i = 0; i < vecs.size(); i++) begin
            bus.i_flt      = vecs[i].flt;
            bus.i_flt_mask = vecs[i].mask;
            bus.i_clr_req  = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d_sticky", i), bus.o_flt_sticky, vecs[i].sticky);
            chk($sformatf("vec%0d_code", i),   bus.o_flt_code,   vecs[i].code);
            chk($sformatf("vec%0d_drv", i),    bus.o_drv_off,    vecs[i].drv);
            chk($sformatf("vec%0d_st", i),     bus.o_fsm_st,     vecs[i].st);
            chk($sformatf("vec%0d_ack", i),    bus.o_clr_ack,    vecs[i].ack);
        end

        // Random phase: slow bits toggle often enough to sometimes qualify,
        // fast bits rarely rise, masks and clears vary, with occasional resets.
        r_flt_hold = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < FLT_NUM; b++) begin
                if (FAST_MSK[b]) begin
                    if (r_flt_hold[b]) r_flt_hold[b] = ($urandom_range(1) == 0);
                    else               r_flt_hold[b] = ($urandom_range(59) == 0);
                end else if ($urandom_range(9) == 0) begin
                    r_flt_hold[b] = ~r_flt_hold[b];
                end
                if ($urandom_range(39) == 0)
                    bus.i_flt_mask[b] = ~bus.i_flt_mask[b];
            end
            bus.i_flt     = r_flt_hold;
            bus.i_clr_req = ($urandom_range(2) == 0);
            if ($urandom_range(799) == 0)
                do_reset("rst_rand");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
